// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath: default geometry, pixel width
// and the signed maximum used by every pooling block.
package pool_pkg;

    localparam int POOL_DATA_W     = 16;
    localparam int POOL_WIDTH_IMG  = 26;
    localparam int POOL_HEIGHT_IMG = 26;

    // Widest pixel the shared comparator accepts; narrower pixels are sign-extended.
    localparam int POOL_MAX_W = 32;

    typedef logic signed [POOL_MAX_W-1:0] pool_word_t;

    function automatic pool_word_t pool_smax(input pool_word_t a, input pool_word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the pairwise maxima of the upper row of each
// 2x2 window; one write port and a combinational read port on the same address.
module pool_line_buf #(
    parameter int DEPTH  = 13,
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; every entry is rewritten by the
    // upper row before the lower row reads it, so reset logic would be wasted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pooling over a raster-order pixel stream, with
// one registered pooled pixel per window and line/frame status pulses.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int WIDTH_IMG  = POOL_WIDTH_IMG,
    parameter int HEIGHT_IMG = POOL_HEIGHT_IMG,
    parameter int DATA_W     = POOL_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     line_done,
    output logic                     frame_done
);

    localparam int CW    = $clog2(WIDTH_IMG);
    localparam int RW    = $clog2(HEIGHT_IMG);
    localparam int DEPTH = WIDTH_IMG / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (WIDTH_IMG < 2 || (WIDTH_IMG % 2) != 0) begin : g_bad_width
            $error("maxpool2x2_stream: WIDTH_IMG must be even and >= 2");
        end
        if (HEIGHT_IMG < 2 || (HEIGHT_IMG % 2) != 0) begin : g_bad_height
            $error("maxpool2x2_stream: HEIGHT_IMG must be even and >= 2");
        end
        if (DATA_W < 1 || DATA_W > POOL_MAX_W) begin : g_bad_data_w
            $error("maxpool2x2_stream: DATA_W exceeds the shared comparator width");
        end
    endgenerate

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] pair;
    logic signed [DATA_W-1:0] pooled;
    logic signed [DATA_W-1:0] lb_rd;
    logic [AW-1:0]            lb_addr;
    logic                     lb_wr;
    logic                     col_last;
    logic                     row_last;
    logic                     restart;

    assign col_last = (col == CW'(WIDTH_IMG - 1));
    assign row_last = (row == RW'(HEIGHT_IMG - 1));
    assign restart  = rst || clear;

    // Horizontal max of the current pair, then vertical max against the buffered upper pair.
    assign pair    = DATA_W'(pool_smax(POOL_MAX_W'(hold), POOL_MAX_W'(in_data)));
    assign pooled  = DATA_W'(pool_smax(POOL_MAX_W'(lb_rd), POOL_MAX_W'(pair)));
    assign lb_addr = AW'(col >> 1);
    assign lb_wr   = !restart && in_valid && col[0] && !row[0];

    pool_line_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .addr    (lb_addr),
        .wr_data (pair),
        .rd_data (lb_rd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (restart) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!col[0]) begin
                    hold <= in_data;
                end else if (row[0]) begin
                    out_valid  <= 1'b1;
                    out_data   <= pooled;
                    line_done  <= col_last;
                    frame_done <= col_last && row_last;
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage in the pooling datapath.
- Consumes a raster-order pixel stream (one pixel per valid cycle) from the convolution/ReLU output.
- Emits one pooled pixel per 2x2 window, in raster order of the pooled map.
- Holds one half-width line buffer of pairwise row maxima, so only WIDTH_IMG/2 words of storage are needed.

Parameters:
- WIDTH_IMG, 26, input feature-map width in pixels; must be even and >= 2.
- HEIGHT_IMG, 26, input feature-map height in rows; must be even and >= 2.
- DATA_W, 16, pixel width; values are signed two's complement.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort; same effect as rst on counters and outputs.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  input pixel, signed.
- out_valid  output  1  out_data is valid; single-cycle pulse per pooled pixel.
- out_data  output  DATA_W  pooled pixel, signed maximum of the 2x2 window.
- line_done  output  1  pulses together with the last pooled pixel of each pooled row.
- frame_done  output  1  pulses together with the last pooled pixel of the frame.

Behaviour:
- Reset/clear:
  - On rst=1 or clear=1 at a clock edge: col=0, row=0, hold=0, out_valid=0, out_data=0, line_done=0, frame_done=0.
  - Line buffer contents are don't-care after reset.
  - rst has priority over clear; clear has priority over in_valid in the same cycle.
- Counters:
  - col runs 0..WIDTH_IMG-1 and row runs 0..HEIGHT_IMG-1.
  - Both advance only on in_valid=1. Gaps of any length are allowed; state is frozen while in_valid=0.
  - At col=WIDTH_IMG-1, col wraps to 0 and row increments.
  - At row=HEIGHT_IMG-1 and col=WIDTH_IMG-1, both wrap to 0. The next frame follows with no idle cycle required.
- Datapath, per accepted pixel:
  - col even: hold <= in_data.
  - col odd: pair = signed max(hold, in_data).
  - row even, col odd: lbuf[col>>1] <= pair. No output.
  - row odd, col odd: out_data <= signed max(lbuf[col>>1], pair), and out_valid <= 1.
  - All other cases: out_valid <= 0.
- Latency: out_valid is asserted on the cycle after the edge that accepted the bottom-right pixel of the window (1-cycle registered output).
- Output rate: at most one output per two accepted pixels; WIDTH_IMG/2 * HEIGHT_IMG/2 outputs per frame (169 at defaults).
- Status pulses:
  - line_done=1 exactly with an output whose source col=WIDTH_IMG-1.
  - frame_done=1 exactly with the output for row=HEIGHT_IMG-1, col=WIDTH_IMG-1.
  - Both are 0 at all other times.
- Comparison: signed max; ties may select either operand since the value is identical.
- Flow control: none. The downstream stage must accept every out_valid pulse.
- Counter widths: $clog2(WIDTH_IMG) and $clog2(HEIGHT_IMG) bits; WIDTH_IMG=26 fits the 5-bit counter width used elsewhere in the pooling path.
- Parameter check: an odd WIDTH_IMG or HEIGHT_IMG is a configuration error and is flagged by an elaboration-time check.

Decomposition:
- Shared package pool_pkg:
  - POOL_DATA_W default.
  - Signed max function, shared with other pooling blocks.
  - Default WIDTH_IMG/HEIGHT_IMG constants.
- One sub-module, pool_line_buf: WIDTH_IMG/2 x DATA_W register array with a write port and a combinational read port, both addressed by col>>1.
- Counters and output registers stay in the top module.

Test Plan:
- WIDTH_IMG=4, HEIGHT_IMG=4, continuous valid, input pixels 0..15 in raster order -> outputs 5, 7, 13, 15; line_done on the 7 and the 15; frame_done on the 15 only.
- Negative values, window {-8,-3,-5,-20} -> out_data = -3. This confirms the comparison is signed, not unsigned.
- Same stream as the first scenario with in_valid deasserted for 3 cycles between every pixel -> identical outputs. Each out_valid falls exactly one cycle after its bottom-right pixel is accepted.
- Two back-to-back frames with no gap -> 8 outputs; frame_done twice; the second frame's outputs are unaffected by the first frame's buffer contents.
- rst asserted mid-frame after 6 pixels, then a fresh 16-pixel frame -> no stale outputs; exactly 4 correct outputs.
- clear and in_valid high in the same cycle at row 1, col 1 -> that pixel is discarded, out_valid stays 0, and counters restart at 0.
